// File: rtl/phone_pkg.sv
// Shared definitions for the phone-number entry sequencer.
//   NUM_DIGITS     : digits in a complete number
//   KEY_DEL/CLR/OK : default control key codes
//   BLANK_CODE     : seven-segment code for a dark digit
//   entry_state_e  : entry FSM states
//   slot_lsb()     : bit position of a digit slot inside the packed number
//   digit_at()     : safe read of one digit slot (0 for out-of-range slots)
package phone_pkg;

  localparam int NUM_DIGITS = 11;
  localparam int NUM_W      = 4 * NUM_DIGITS;

  localparam logic [3:0] KEY_DEL = 4'hA;
  localparam logic [3:0] KEY_CLR = 4'hB;
  localparam logic [3:0] KEY_OK  = 4'hC;

  localparam logic [4:0] BLANK_CODE = 5'h10;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ENTRY,
    ST_FULL,
    ST_LOCKED
  } entry_state_e;

  // Digit 0 (first dialled) sits in the top nibble.
  function automatic int slot_lsb(input int k);
    return 4 * (NUM_DIGITS - 1 - k);
  endfunction

  function automatic logic [3:0] digit_at(input logic [NUM_W-1:0] num, input logic [3:0] k);
    logic [3:0] d;
    d = 4'h0;
    if (k < 4'(NUM_DIGITS)) d = num[slot_lsb(int'(k)) +: 4];
    return d;
  endfunction

endpackage

// File: rtl/page_scroller.sv
// Display page selector: manual page from disp_sel, or auto-scroll through
// pages 0->1->2->0 with a dwell of SCROLL_CYCLES clocks when disp_sel==11.
//   clk, reset : system clock, synchronous active-high reset
//   disp_sel   : 00/01/10 manual page, 11 auto-scroll
//   page       : current page (0..2)
module page_scroller #(
  parameter int SCROLL_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] disp_sel,
  output logic [1:0] page
);

  localparam int            CW   = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(SCROLL_CYCLES - 1);

  logic [CW-1:0] dwell_q;

  // Manual mode parks the dwell counter at 0 so auto mode always starts a
  // fresh full dwell on whatever page was last shown.
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_q <= '0;
      page    <= 2'd0;
    end else if (disp_sel != 2'b11) begin
      dwell_q <= '0;
      page    <= disp_sel;
    end else if (dwell_q == TERM) begin
      dwell_q <= '0;
      page    <= (page == 2'd2) ? 2'd0 : page + 2'd1;
    end else begin
      dwell_q <= dwell_q + 1'b1;
    end
  end

endmodule

// File: rtl/phone_entry_ctrl.sv
// Phone-number entry sequencer between the key scanner and a 4-digit
// seven-segment driver.
//   clk, reset        : 50 MHz clock, synchronous active-high reset
//   key_flag/value    : one-cycle key event, 0-9 digit, A del, B clr, C ok
//   del_pulse         : dedicated delete button pulse (wins over key_flag)
//   disp_sel          : manual page 0..2 or 11 = auto-scroll
//   phone_number      : 11 packed digits, digit 0 at [43:40]
//   digit_count       : digits entered, 0..11
//   locked            : number confirmed
//   done / err        : one-cycle pulses for confirm / rejected key
//   in_4..in_1        : seg codes, bit4 = blank
module phone_entry_ctrl
  import phone_pkg::*;
#(
  parameter int         SCROLL_CYCLES = 50_000_000,
  parameter logic [3:0] CODE_DEL      = KEY_DEL,
  parameter logic [3:0] CODE_CLR      = KEY_CLR,
  parameter logic [3:0] CODE_OK       = KEY_OK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_flag,
  input  logic [3:0]       key_value,
  input  logic             del_pulse,
  input  logic [1:0]       disp_sel,
  output logic [NUM_W-1:0] phone_number,
  output logic [3:0]       digit_count,
  output logic             locked,
  output logic             done,
  output logic             err,
  output logic [4:0]       in_4,
  output logic [4:0]       in_3,
  output logic [4:0]       in_2,
  output logic [4:0]       in_1
);

  localparam logic [3:0] FULL_CNT = 4'(NUM_DIGITS);

  entry_state_e     state_q, state_n;
  logic [3:0]       cnt_q, cnt_n;
  logic [NUM_W-1:0] num_q, num_n;
  logic             done_q, done_n, err_q, err_n;
  logic [3:0][4:0]  disp_d, disp_q;
  logic [1:0]       page;
  logic             do_del;
  logic [3:0]       cnt_m1;

  // A delete from either source absorbs any key event in the same cycle.
  assign do_del = del_pulse | (key_flag & (key_value == CODE_DEL));
  assign cnt_m1 = cnt_q - 4'd1;

  // State register (data path registers ride along with the FSM state).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
      num_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      num_q   <= num_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    num_n   = num_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    if (do_del) begin
      if (cnt_q == 4'd0 || state_q == ST_LOCKED) begin
        err_n = 1'b1;
      end else begin
        num_n[slot_lsb(int'(cnt_m1)) +: 4] = 4'h0;
        cnt_n   = cnt_m1;
        state_n = (cnt_m1 == 4'd0) ? ST_EMPTY : ST_ENTRY;
      end
    end else if (key_flag) begin
      if (key_value <= 4'd9) begin
        if (state_q == ST_FULL || state_q == ST_LOCKED) begin
          err_n = 1'b1;
        end else begin
          num_n[slot_lsb(int'(cnt_q)) +: 4] = key_value;
          cnt_n   = cnt_q + 4'd1;
          state_n = (cnt_n == FULL_CNT) ? ST_FULL : ST_ENTRY;
        end
      end else if (key_value == CODE_CLR) begin
        num_n   = '0;
        cnt_n   = '0;
        state_n = ST_EMPTY;
      end else if (key_value == CODE_OK) begin
        if (state_q == ST_FULL) begin
          state_n = ST_LOCKED;
          done_n  = 1'b1;
        end else begin
          err_n = 1'b1;
        end
      end
      // Remaining codes (D-F) are silently ignored.
    end
  end

  // Output logic.
  always_comb begin
    locked       = (state_q == ST_LOCKED);
    phone_number = num_q;
    digit_count  = cnt_q;
    done         = done_q;
    err          = err_q;
  end

  page_scroller #(
    .SCROLL_CYCLES(SCROLL_CYCLES)
  ) u_scroll (
    .clk     (clk),
    .reset   (reset),
    .disp_sel(disp_sel),
    .page    (page)
  );

  // Lane 3 drives in_4 (leftmost) and shows slot 4*page; lane 0 drives in_1.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [3:0] slot;
    assign slot = {page, 2'b00} + 4'(3 - i);
    always_comb begin
      disp_d[i] = BLANK_CODE;
      if (slot < cnt_q) disp_d[i] = {1'b0, digit_at(num_q, slot)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) disp_q <= {4{BLANK_CODE}};
    else       disp_q <= disp_d;
  end

  assign {in_4, in_3, in_2, in_1} = disp_q;

endmodule

// File: tb/tb_phone_entry_ctrl.sv
// Scoreboard bench for phone_entry_ctrl: each stimulus cycle pushes the
// expected post-edge outputs; a monitor pops and compares after every edge.
module tb_phone_entry_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_flag;
  logic [3:0]  key_value;
  logic        del_pulse;
  logic [1:0]  disp_sel;
  logic [43:0] phone_number;
  logic [3:0]  digit_count;
  logic        locked, done, err;
  logic [4:0]  in_4, in_3, in_2, in_1;

  always #5 clk = ~clk;

  phone_entry_ctrl #(.SCROLL_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_flag    (key_flag),
    .key_value   (key_value),
    .del_pulse   (del_pulse),
    .disp_sel    (disp_sel),
    .phone_number(phone_number),
    .digit_count (digit_count),
    .locked      (locked),
    .done        (done),
    .err         (err),
    .in_4        (in_4),
    .in_3        (in_3),
    .in_2        (in_2),
    .in_1        (in_1)
  );

  typedef struct {
    logic [3:0]  cnt;
    logic [43:0] num;
    logic        lock;
    logic        done;
    logic        err;
    logic        cd;
    logic [19:0] disp;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [3:0]  exp_cnt;
  logic [43:0] exp_num;
  logic        exp_lock;
  logic [1:0]  cur_ds;

  localparam logic [19:0] BLANK4 = {4{5'h10}};
  localparam logic [19:0] P0 = {5'h01, 5'h03, 5'h08, 5'h00};
  localparam logic [19:0] P1 = {5'h00, 5'h01, 5'h03, 5'h08};
  localparam logic [19:0] P2 = {5'h00, 5'h00, 5'h00, 5'h10};

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, want, $time);
    end
  endfunction

  // Monitor: outputs are sampled 1 time unit after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("digit_count", 64'(digit_count), 64'(e.cnt));
        chk("phone_number", 64'(phone_number), 64'(e.num));
        chk("locked", 64'(locked), 64'(e.lock));
        chk("done", 64'(done), 64'(e.done));
        chk("err", 64'(err), 64'(e.err));
        if (e.cd) chk("display", 64'({in_4, in_3, in_2, in_1}), 64'(e.disp));
      end
    end
  end

  // One stimulus cycle: drive after an edge, expectation applies after the next edge.
  task automatic step(input logic rs, input logic kf, input logic [3:0] kv, input logic dp,
                      input logic e_done, input logic e_err, input logic cd, input logic [19:0] ed);
    exp_t e;
    @(posedge clk);
    #2;
    reset = rs; disp_sel = cur_ds; key_flag = kf; key_value = kv; del_pulse = dp;
    e.cnt = exp_cnt; e.num = exp_num; e.lock = exp_lock;
    e.done = e_done; e.err = e_err; e.cd = cd; e.disp = ed;
    sbq.push_back(e);
  endtask

  task automatic idle(input logic cd, input logic [19:0] ed);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, cd, ed);
  endtask

  task automatic key(input logic [3:0] kv, input logic e_err);
    step(1'b0, 1'b1, kv, 1'b0, 1'b0, e_err, 1'b0, 20'h0);
  endtask

  // Accepted digit: lands in slot exp_cnt (digit 0 in the top nibble).
  task automatic dig(input logic [3:0] d);
    exp_num[4*(10-int'(exp_cnt)) +: 4] = d;
    exp_cnt = exp_cnt + 4'd1;
    key(d, 1'b0);
  endtask

  initial begin
    logic [19:0] pg [3];
    pg[0] = P0; pg[1] = P1; pg[2] = P2;
    reset = 1'b1; key_flag = 1'b0; key_value = 4'h0; del_pulse = 1'b0;
    cur_ds = 2'd0; disp_sel = 2'd0;
    exp_cnt = 4'd0; exp_num = 44'h0; exp_lock = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, BLANK4);
    idle(1'b1, BLANK4);

    // 1,3,8,0 with partial and full page-0 display
    dig(4'd1); dig(4'd3);
    idle(1'b1, {5'h01, 5'h03, 5'h10, 5'h10});
    dig(4'd8); dig(4'd0);
    idle(1'b1, P0);
    if (exp_num !== 44'h13800000000) begin
      n_fail++; $display("FAIL model_1380: got %0h, expected 13800000000", exp_num);
    end

    // Complete 13800138000, digit while FULL rejected
    dig(4'd0); dig(4'd1); dig(4'd3); dig(4'd8); dig(4'd0); dig(4'd0); dig(4'd0);
    idle(1'b1, P0);
    key(4'd5, 1'b1);
    idle(1'b0, 20'h0);

    // Confirm: single done pulse
    exp_lock = 1'b1;
    step(1'b0, 1'b1, 4'hC, 1'b0, 1'b1, 1'b0, 1'b0, 20'h0);
    idle(1'b0, 20'h0);
    key(4'd5, 1'b1);
    idle(1'b0, 20'h0);
    key(4'hC, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 20'h0);
    key(4'hA, 1'b1);
    idle(1'b0, 20'h0);

    // Manual pages
    cur_ds = 2'd2; idle(1'b0, 20'h0); idle(1'b1, P2);
    cur_ds = 2'd1; idle(1'b0, 20'h0); idle(1'b1, P1);
    cur_ds = 2'd0; idle(1'b0, 20'h0); idle(1'b1, P0);

    // Auto-scroll, dwell of 4 clocks, display one clock behind the page
    cur_ds = 2'd3;
    for (int k = 1; k <= 16; k++) idle(1'b1, pg[((k-1)/4) % 3]);
    cur_ds = 2'd1; idle(1'b1, P1); idle(1'b1, P1);
    cur_ds = 2'd0; idle(1'b0, 20'h0); idle(1'b1, P0);

    // Clear while locked
    exp_cnt = 4'd0; exp_num = 44'h0; exp_lock = 1'b0;
    key(4'hB, 1'b0);
    idle(1'b1, BLANK4);

    // Errors on an empty number
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 20'h0);
    key(4'hA, 1'b1);
    key(4'hC, 1'b1);

    // Simultaneous delete sources
    dig(4'd1); dig(4'd2); dig(4'd3); dig(4'd4); dig(4'd5);
    exp_cnt = 4'd4; exp_num = 44'h12340000000;
    step(1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 20'h0);
    exp_cnt = 4'd3; exp_num = 44'h12300000000;
    key(4'hA, 1'b0);
    exp_cnt = 4'd2; exp_num = 44'h12000000000;
    step(1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 20'h0);
    idle(1'b1, {5'h01, 5'h02, 5'h10, 5'h10});

    // Ignored codes
    key(4'hD, 1'b0);
    key(4'hF, 1'b0);

    // OK at 10 digits rejected; delete out of FULL; confirm at 11
    for (int d = 0; d < 8; d++) dig(4'(d));
    key(4'hC, 1'b1);
    dig(4'd9);
    exp_cnt = 4'd10; exp_num = 44'h12012345670;
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h0);
    dig(4'd9);
    exp_lock = 1'b1;
    step(1'b0, 1'b1, 4'hC, 1'b0, 1'b1, 1'b0, 1'b0, 20'h0);
    exp_cnt = 4'd0; exp_num = 44'h0; exp_lock = 1'b0;
    key(4'hB, 1'b0);

    // Reset mid-entry with a would-be error in the same cycle
    for (int d = 0; d < 6; d++) dig(4'(d + 1));
    exp_cnt = 4'd0; exp_num = 44'h0;
    step(1'b1, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 1'b1, BLANK4);
    idle(1'b1, BLANK4);
    idle(1'b0, 20'h0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    @(posedge clk); #3;
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
